// File: rtl/text_buffer_pkg.sv
// Shared definitions for the text buffer: command encoding and engine states.
package text_buffer_pkg;

  // Command opcode presented on cmd_op.
  typedef enum logic {
    CMD_CLEAR  = 1'b0,
    CMD_SCROLL = 1'b1
  } cmd_op_e;

  // Command engine states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    SCR_RD   = 3'd2,
    SCR_WR   = 3'd3,
    SCR_FILL = 3'd4
  } state_e;

endpackage

// File: rtl/text_ram_dp.sv
// Character RAM with a read-only video port (A) and a read/write port (B).
// Both read ports are registered; out-of-range reads return FILL and
// out-of-range writes are dropped. Contents power up as FILL and are not
// touched by reset.
module text_ram_dp #(
  parameter int                 DEPTH  = 960,
  parameter int                 DATA_W = 8,
  parameter int                 ADR_W  = 16,
  parameter logic [DATA_W-1:0]  FILL   = 8'hA0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADR_W-1:0]  a_adr_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [ADR_W-1:0]  b_adr_i,
  input  logic              b_we_i,
  input  logic              b_re_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADR_W-1:0] DEPTH_A = ADR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL};
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              a_in_range_s;
  logic              b_in_range_s;
  logic [AW-1:0]     a_idx_s;
  logic [AW-1:0]     b_idx_s;

  assign a_in_range_s = (a_adr_i < DEPTH_A);
  assign b_in_range_s = (b_adr_i < DEPTH_A);
  assign a_idx_s      = a_adr_i[AW-1:0];
  assign b_idx_s      = b_adr_i[AW-1:0];

  // Video port: read every cycle, FILL outside the screen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
    end else if (a_in_range_s) begin
      a_rdata_q <= mem[a_idx_s];
    end else begin
      a_rdata_q <= FILL;
    end
  end

  // Port B write: only in-range cells are updated.
  always_ff @(posedge clk_i) begin
    if (b_we_i && b_in_range_s) begin
      mem[b_idx_s] <= b_wdata_i;
    end
  end

  // Port B read: data held between reads, FILL outside the screen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_rdata_q <= '0;
    end else if (b_re_i) begin
      b_rdata_q <= b_in_range_s ? mem[b_idx_s] : FILL;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/text_buffer.sv
// Text-mode character store: free-running video read port, arbitrated CPU
// port, and a clear / scroll-up-one-row command engine sharing RAM port B.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int                COLS   = 40,
  parameter int                ROWS   = 24,
  parameter int                DATA_W = 8,
  parameter int                ADR_W  = 16,
  parameter logic [DATA_W-1:0] FILL   = 8'hA0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADR_W-1:0]  vid_adr,
  output logic [DATA_W-1:0] vid_d,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  output logic              cmd_ready,
  output logic              busy
);

  localparam int               DEPTH      = COLS * ROWS;
  localparam logic [ADR_W-1:0] ONE_A      = ADR_W'(1);
  localparam logic [ADR_W-1:0] COLS_A     = ADR_W'(COLS);
  localparam logic [ADR_W-1:0] LAST_A     = ADR_W'(DEPTH - 1);
  localparam logic [ADR_W-1:0] SCR_LAST_A = ADR_W'(DEPTH - COLS - 1);
  localparam logic [ADR_W-1:0] FILL_ST_A  = ADR_W'(DEPTH - COLS);

  state_e             state_q;
  state_e             state_d;
  logic [ADR_W-1:0]   idx_q;
  logic [ADR_W-1:0]   idx_d;
  logic               busy_q;
  logic               ready_q;
  logic               rvalid_q;
  logic               cmd_fire_s;

  logic [ADR_W-1:0]   b_adr_s;
  logic               b_we_s;
  logic               b_re_s;
  logic [DATA_W-1:0]  b_wdata_s;
  logic [DATA_W-1:0]  b_rdata_s;

  // CPU traffic has priority: a command is only offered when no access is pending.
  assign cmd_ready  = ready_q & ~cpu_we & ~cpu_re;
  assign cmd_fire_s = cmd_valid & cmd_ready;

  // Engine next-state and cell index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire_s) begin
          idx_d = '0;
          if (cmd_op == CMD_CLEAR) begin
            state_d = CLR;
          end else if (ROWS == 1) begin
            state_d = SCR_FILL;
          end else begin
            state_d = SCR_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLR, SCR_FILL: begin
        if (idx_q == LAST_A) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ONE_A;
        end
      end
      SCR_RD: begin
        state_d = SCR_WR;
      end
      SCR_WR: begin
        if (idx_q == SCR_LAST_A) begin
          state_d = SCR_FILL;
          idx_d   = FILL_ST_A;
        end else begin
          state_d = SCR_RD;
          idx_d   = idx_q + ONE_A;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Port B mux: CPU owns it in IDLE, the engine everywhere else.
  always_comb begin
    b_adr_s   = cpu_adr;
    b_we_s    = 1'b0;
    b_re_s    = 1'b0;
    b_wdata_s = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          b_we_s = 1'b1;
        end else if (cpu_re) begin
          b_re_s = 1'b1;
        end else begin
          b_we_s = 1'b0;
        end
      end
      CLR, SCR_FILL: begin
        b_adr_s   = idx_q;
        b_we_s    = 1'b1;
        b_wdata_s = FILL;
      end
      SCR_RD: begin
        b_adr_s = idx_q + COLS_A;
        b_re_s  = 1'b1;
      end
      SCR_WR: begin
        b_adr_s   = idx_q;
        b_we_s    = 1'b1;
        b_wdata_s = b_rdata_s;
      end
      default: begin
        b_we_s = 1'b0;
      end
    endcase
  end

  // Engine state, index and derived handshake flags.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == IDLE);
      rvalid_q <= ready_q & ~cpu_we & cpu_re;
    end
  end

  text_ram_dp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W),
    .FILL   (FILL)
  ) u_ram (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .a_adr_i   (vid_adr),
    .a_rdata_o (vid_d),
    .b_adr_i   (b_adr_s),
    .b_we_i    (b_we_s),
    .b_re_i    (b_re_s),
    .b_wdata_i (b_wdata_s),
    .b_rdata_o (b_rdata_s)
  );

  assign cpu_ready  = ready_q;
  assign cpu_rdata  = b_rdata_s;
  assign cpu_rvalid = rvalid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_buffer.sv
// Randomised self-checking bench for text_buffer with a screen-level model.
module tb_text_buffer;

  localparam int        COLS  = 40;
  localparam int        ROWS  = 24;
  localparam int        DEPTH = COLS * ROWS;
  localparam logic [7:0] FILL = 8'hA0;
  localparam int        BUDGET = 5000;

  logic        clk;
  logic        rst;
  logic [15:0] vid_adr;
  logic [7:0]  vid_d;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cmd_valid;
  logic        cmd_op;
  logic        cmd_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [DEPTH];

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(8), .ADR_W(16), .FILL(FILL)) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .vid_adr    (vid_adr),
    .vid_d      (vid_d),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen-level reference operations.
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = FILL;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        model[r*COLS + c] = model[(r+1)*COLS + c];
    for (int c = 0; c < COLS; c++) model[(ROWS-1)*COLS + c] = FILL;
  endtask

  function automatic logic [7:0] expect_at(input int adr);
    if (adr < DEPTH) return model[adr];
    return FILL;
  endfunction

  task automatic vid_check(input int adr, input string tag);
    logic [7:0] exp;
    vid_adr = 16'(adr);
    @(negedge clk);
    exp = expect_at(adr);
    checks++;
    if (vid_d !== exp) begin
      errors++;
      $display("FAIL %s vid adr %0d: got %h expected %h", tag, adr, vid_d, exp);
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) vid_check(i, tag);
  endtask

  task automatic cpu_write(input int adr, input logic [7:0] data);
    int n;
    cpu_we    = 1'b1;
    cpu_adr   = 16'(adr);
    cpu_wdata = data;
    n = 0;
    while (cpu_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL cpu_write_timeout adr %0d: ready %b expected 1", adr, cpu_ready);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    if (adr < DEPTH) model[adr] = data;
  endtask

  task automatic cpu_read(input int adr, input string tag);
    int n;
    logic [7:0] exp;
    cpu_re  = 1'b1;
    cpu_adr = 16'(adr);
    n = 0;
    while (cpu_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cpu_re = 1'b0;
    exp = expect_at(adr);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp) begin
      errors++;
      $display("FAIL %s cpu read adr %0d: got valid %b data %h expected valid 1 data %h",
               tag, adr, cpu_rvalid, cpu_rdata, exp);
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s rvalid pulse: got %b expected 0", tag, cpu_rvalid);
    end
  endtask

  // Issue a command at a negedge in IDLE and measure its busy time.
  task automatic issue_cmd(input logic op, input int exp_cycles, input string tag);
    int cycles;
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready: got %b expected 1", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < BUDGET) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", tag, cycles, exp_cycles);
    end
    if (op == 1'b0) model_clear();
    else model_scroll();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vid_adr = '0; cpu_adr = '0; cpu_wdata = '0;
    cpu_we = 1'b0; cpu_re = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (vid_d !== 8'h00 || cpu_rdata !== 8'h00 || cpu_rvalid !== 1'b0 || busy !== 1'b0 ||
        cpu_ready !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got vid %h rdata %h rvalid %b busy %b ready %b cmd_ready %b expected 00 00 0 0 1 1",
               vid_d, cpu_rdata, cpu_rvalid, busy, cpu_ready, cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    sweep("powerup");
    vid_check(1000, "vid_oor");
    vid_check(65535, "vid_oor_max");
  endtask

  task automatic test_cpu_rw();
    int a;
    cpu_write(15, 8'h08);
    cpu_read(15, "rd15");
    vid_check(15, "vid15");
    cpu_write(1000, 8'h5A);
    cpu_read(1000, "rd_oor");
    vid_check(1000, "vid_oor_after_write");
    cpu_read(DEPTH - 1, "rd_last");
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 1100));
      cpu_write(a, 8'($urandom));
      cpu_read(a, "rd_rand");
      vid_check(a, "vid_rand");
      cpu_read(int'($urandom_range(0, DEPTH - 1)), "rd_rand_other");
    end
  endtask

  task automatic test_clear();
    int cycles;
    int ready_bad;
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'(i & 8'hFF));
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear cmd_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cpu_we    = 1'b1;
    cpu_adr   = 16'd77;
    cpu_wdata = 8'h3C;
    cycles = 0;
    ready_bad = 0;
    while (busy === 1'b1 && cycles < BUDGET) begin
      if (cpu_ready !== 1'b0) ready_bad++;
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != DEPTH) begin
      errors++;
      $display("FAIL clear busy cycles: got %0d expected %0d", cycles, DEPTH);
    end
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL clear cpu_ready_low: got %0d high cycles expected 0", ready_bad);
    end
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear first_idle_ready: got %b expected 1", cpu_ready);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    model_clear();
    model[77] = 8'h3C;
    sweep("after_clear");
  endtask

  task automatic test_scroll();
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'(i / COLS));
    issue_cmd(1'b1, 2*(DEPTH - COLS) + COLS, "scroll");
    sweep("after_scroll");
  endtask

  task automatic test_simultaneous();
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cpu_we    = 1'b1;
    cpu_adr   = 16'd100;
    cpu_wdata = 8'hC3;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul arbitration: got cmd_ready %b cpu_ready %b expected 0 1", cmd_ready, cpu_ready);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    model[100] = 8'hC3;
    #1;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul after_write: got busy %b cmd_ready %b expected 0 1", busy, cmd_ready);
    end
    issue_cmd(1'b1, 2*(DEPTH - COLS) + COLS, "simul_scroll");
    vid_check(60, "simul_moved_cell");
    sweep("after_simul");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) cpu_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
    issue_cmd(1'b1, 2*(DEPTH - COLS) + COLS, "b2b_first");
    issue_cmd(1'b1, 2*(DEPTH - COLS) + COLS, "b2b_second");
    issue_cmd(1'b0, DEPTH, "b2b_third");
    vid_check(int'($urandom_range(0, DEPTH - 1)), "b2b_cell");
  endtask

  task automatic test_reset_mid_scroll();
    for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'($urandom));
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset state: got busy %b ready %b expected 0 1", busy, cpu_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Only the first 49 cells have received their scrolled value.
    for (int i = 0; i < 49; i++) model[i] = model[i + COLS];
    sweep("after_midreset");
    issue_cmd(1'b0, DEPTH, "clear_after_reset");
    sweep("after_reset_clear");
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_clear();
    test_scroll();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_scroll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
